mode_alu_arbiter: RTL and testbench

MODE_ALU_ARBITER -- requirements
Module: mode_alu_arbiter

---
 rtl/mode_alu_arbiter_pkg.sv | 42 ++++
 rtl/mode_alu_arbiter_if.sv | 31 +++
 rtl/mode_alu_arbiter_div.sv | 86 ++++++++
 rtl/mode_alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_mode_alu_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mode_alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mode_alu_pkg
// Brief    : Shared widths, mode encodings, FSM states and the single-cycle ALU.
// Revision : 1.0
// ============================================================================
package mode_alu_pkg;

  localparam int unsigned OPW = 8;

  localparam logic [2:0] MODE_ADDSUB_A = 3'b001;
  localparam logic [2:0] MODE_ADDSUB_B = 3'b010;
  localparam logic [2:0] MODE_MULDIV   = 3'b011;
  localparam logic [2:0] MODE_MAXADD   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Single-cycle result; the divide leg of MODE_MULDIV yields zero here and
  // is replaced by the iterative divider when that is built in.
  function automatic logic [OPW-1:0] alu_single(input logic [2:0]     mode,
                                                input logic [OPW-1:0] a,
                                                input logic [OPW-1:0] b);
    logic [2*OPW-1:0] prod;
    logic [OPW-1:0]   res;
    prod = {{OPW{1'b0}}, a} * {{OPW{1'b0}}, b};
    case (mode)
      MODE_ADDSUB_A,
      MODE_ADDSUB_B: res = (a > b) ? (a + b) : (a - b);
      MODE_MULDIV:   res = (a < b) ? prod[OPW-1:0] : '0;
      MODE_MAXADD:   res = (a != b) ? ((a > b) ? a : b) : (a + b);
      default:       res = a ^ b;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mode_alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mode_alu_arbiter_if
// Brief    : Two-requester request bus plus single response channel.
// Revision : 1.0
// ============================================================================
interface mode_alu_arbiter_if;
  import mode_alu_pkg::*;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][2:0]     req_mode;
  logic [1:0][OPW-1:0] req_a;
  logic [1:0][OPW-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [OPW-1:0]      rsp_data;

  modport master (
    output req_valid, req_mode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface
`default_nettype wire

// File: rtl/mode_alu_arbiter_div.sv
`default_nettype none
// ============================================================================
// Module   : mode_alu_div
// Brief    : 8-step restoring divider, one quotient bit per cycle, MSB first.
//            Present only when MODE_ALU_DIV_EN is defined.
// Revision : 1.0
// ============================================================================
`ifdef MODE_ALU_DIV_EN
module mode_alu_div
  import mode_alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] dividend,
  input  logic [OPW-1:0] divisor,
  output logic           done,
  output logic [OPW-1:0] quotient
);

  logic [OPW-1:0] rem_q, rem_d;
  logic [OPW-1:0] quo_q, quo_d;
  logic [OPW-1:0] dsr_q, dsr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           run_q, run_d;

  logic [OPW:0]   shifted;
  logic [OPW:0]   diff;
  logic           ge;
  logic [OPW-1:0] rem_step;
  logic [OPW-1:0] quo_step;

  always_comb begin
    shifted  = {rem_q, quo_q[OPW-1]};
    diff     = shifted - {1'b0, dsr_q};
    ge       = (shifted >= {1'b0, dsr_q});
    rem_step = ge ? diff[OPW-1:0] : shifted[OPW-1:0];
    quo_step = {quo_q[OPW-2:0], ge};
  end

  // done and quotient are combinational so the owner can capture the final
  // bit in the same cycle the eighth step is taken.
  assign done     = run_q && (cnt_q == 3'd7);
  assign quotient = quo_step;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dsr_d = divisor;
      cnt_d = 3'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= 3'd0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/mode_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mode_alu_arbiter
// Brief    : Round-robin two-requester arbiter feeding a mode-selected ALU.
//            MODE_ALU_DIV_EN adds the iterative divide path for mode 011.
// Revision : 1.0
// ============================================================================
module mode_alu_arbiter
  import mode_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mode_alu_arbiter_if.slave bus,
  output logic              busy
);

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           id_q, id_d;
  logic [2:0]     mode_q, mode_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [OPW-1:0] rsp_data_q, rsp_data_d;

  logic any_valid;
  logic win_id;
  logic grant_en;

  assign any_valid = |bus.req_valid;
  assign win_id    = (bus.req_valid == 2'b11) ? ptr_q : bus.req_valid[1];
  // Gate with rst so req_ready is low during reset even though state is IDLE.
  assign grant_en  = (state_q == ST_IDLE) && any_valid && !rst;

`ifdef MODE_ALU_DIV_EN
  logic           is_div;
  logic           div_start;
  logic           div_done;
  logic [OPW-1:0] div_divisor;
  logic [OPW-1:0] div_quotient;

  assign is_div      = (mode_q == MODE_MULDIV) && (a_q >= b_q);
  assign div_divisor = (b_q == '0) ? {{(OPW-1){1'b0}}, 1'b1} : b_q;
  assign div_start   = (state_q == ST_EXEC) && is_div;

  mode_alu_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (a_q),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      mode_q     <= 3'd0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      mode_q     <= mode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
`ifdef MODE_ALU_DIV_EN
        if (is_div) begin
          state_d = ST_DIV;
        end
`endif
      end
      ST_DIV: begin
`ifdef MODE_ALU_DIV_EN
        if (div_done) begin
          state_d = ST_RESP;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d         = ptr_q;
    id_d          = id_q;
    mode_d        = mode_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_data_d    = rsp_data_q;
    bus.req_ready = 2'b00;
    bus.rsp_valid = (state_q == ST_RESP);
    bus.rsp_id    = id_q;
    bus.rsp_data  = rsp_data_q;
    busy          = (state_q != ST_IDLE);

    if (grant_en) begin
      bus.req_ready = win_id ? 2'b10 : 2'b01;
      id_d          = win_id;
      mode_d        = bus.req_mode[win_id];
      a_d           = bus.req_a[win_id];
      b_d           = bus.req_b[win_id];
      ptr_d         = ~win_id;
    end

    if (state_q == ST_EXEC) begin
      rsp_data_d = alu_single(mode_q, a_q, b_q);
    end
`ifdef MODE_ALU_DIV_EN
    if ((state_q == ST_DIV) && div_done) begin
      rsp_data_d = div_quotient;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_mode_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mode_alu_arbiter
// Brief    : Directed and random stimulus against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_mode_alu_arbiter;

`ifdef MODE_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mode_alu_arbiter_if bus();

  mode_alu_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  bit m_busy;
  int m_id, m_data, m_due, m_ptr;
  int cyc, grant_cyc;
  int hs_data, hs_id, hs_lat, hs_cyc, hs_cnt;
  int id_log[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ref_result(input int mode, input int a, input int b);
    case (mode)
      1, 2: return (a > b) ? (a + b) % 256 : (a - b + 256) % 256;
      3: begin
        if (a < b) return (a * b) % 256;
        if (DIV_EN) return a / ((b == 0) ? 1 : b);
        return 0;
      end
      4: return (a != b) ? ((a > b) ? a : b) : (a + b) % 256;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int ref_latency(input int mode, input int a, input int b);
    return (DIV_EN && mode == 3 && a >= b) ? 10 : 2;
  endfunction

  task automatic drive(input int v, input int m0, input int a0, input int b0,
                       input int m1, input int a1, input int b1, input bit rr);
    bus.req_valid   = v[1:0];
    bus.req_mode[0] = m0[2:0];
    bus.req_a[0]    = a0[7:0];
    bus.req_b[0]    = b0[7:0];
    bus.req_mode[1] = m1[2:0];
    bus.req_a[1]    = a1[7:0];
    bus.req_b[1]    = b1[7:0];
    bus.rsp_ready   = rr;
  endtask

  // One clock cycle: inputs were set just after a negedge; check, then advance.
  task automatic step();
    int  exp_rdy;
    int  w;
    bit  vld_exp;
    #1;
    chk("busy", int'(busy), int'(m_busy));
    vld_exp = m_busy && (cyc >= m_due);
    chk("rsp_valid", int'(bus.rsp_valid), int'(vld_exp));
    if (vld_exp) begin
      chk("rsp_id", int'(bus.rsp_id), m_id);
      chk("rsp_data", int'(bus.rsp_data), m_data);
    end
    exp_rdy = 0;
    if (!m_busy && bus.req_valid != 2'b00) begin
      w         = (bus.req_valid == 2'b11) ? m_ptr : (bus.req_valid[1] ? 1 : 0);
      exp_rdy   = 1 << w;
      m_busy    = 1'b1;
      m_id      = w;
      m_data    = ref_result(int'(bus.req_mode[w]), int'(bus.req_a[w]), int'(bus.req_b[w]));
      m_due     = cyc + ref_latency(int'(bus.req_mode[w]), int'(bus.req_a[w]), int'(bus.req_b[w]));
      m_ptr     = 1 - w;
      grant_cyc = cyc;
    end
    chk("req_ready", int'(bus.req_ready), exp_rdy);
    if (vld_exp && bus.rsp_ready) begin
      hs_data = int'(bus.rsp_data);
      hs_id   = int'(bus.rsp_id);
      hs_lat  = cyc - grant_cyc;
      hs_cyc  = cyc;
      hs_cnt++;
      id_log.push_back(int'(bus.rsp_id));
      m_busy  = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1);
    repeat (n) step();
  endtask

  task automatic run_one(input int m, input int a, input int b);
    drive(1, m, a, b, 0, 0, 0, 1'b1);
    step();
    idle(12);
  endtask

  initial begin
    int base;
    int hs_before;
    int a;
    int b;

    rst = 1'b0;
    drive(3, 1, 1, 1, 1, 1, 1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_rsp_data", int'(bus.rsp_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_busy = 1'b0;
    m_ptr  = 0;
    cyc    = 0;
    hs_cnt = 0;
    idle(2);

    // Basic add, then divide / divide-by-zero, multiply and max/add cases.
    run_one(1, 10, 3);
    chk("add_data", hs_data, 13);
    chk("add_id", hs_id, 0);
    chk("add_lat", hs_lat, 2);

    run_one(3, 200, 7);
    chk("div_data", hs_data, DIV_EN ? 28 : 0);
    chk("div_lat", hs_lat, DIV_EN ? 10 : 2);
    run_one(3, 200, 0);
    chk("div0_data", hs_data, DIV_EN ? 200 : 0);

    run_one(3, 20, 30);
    chk("mul_data", hs_data, 8'h58);
    run_one(4, 128, 128);
    chk("maxeq_data", hs_data, 0);
    run_one(4, 5, 9);
    chk("max_data", hs_data, 9);

    // Both requesters always valid: grants must alternate.
    base = id_log.size();
    for (int i = 0; i < 24; i++) begin
      drive(3, 0, $urandom_range(0, 255), $urandom_range(0, 255),
               0, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
      step();
    end
    idle(4);
    chk("alt_count", int'(id_log.size() - base >= 6), 1);
    for (int k = base + 1; k < id_log.size(); k++) begin
      chk("alt_id", id_log[k], id_log[k-1] ^ 1);
    end

    // Response back-pressure for 5 cycles with the other requester pending.
    drive(3, 1, 50, 20, 0, 1, 2, 1'b0);
    step();
    repeat (6) step();
    drive(3, 1, 50, 20, 0, 1, 2, 1'b1);
    step();
    step();
    chk("bp_regrant", grant_cyc - hs_cyc, 1);
    idle(12);

    // Reset during the fourth divide cycle (or mid-response without divider).
    drive(1, 3, 200, 7, 0, 0, 0, 1'b0);
    step();
    drive(3, 3, 200, 7, 0, 0, 0, 1'b0);
    repeat (4) step();
    hs_before = hs_cnt;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("mid_rst_req_ready", int'(bus.req_ready), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rsp_id", int'(bus.rsp_id), 0);
    chk("mid_rst_rsp_data", int'(bus.rsp_data), 0);
    @(negedge clk);
    rst    = 1'b0;
    m_busy = 1'b0;
    m_ptr  = 0;
    cyc++;
    idle(12);
    chk("mid_rst_no_rsp", hs_cnt, hs_before);
    run_one(1, 10, 3);
    chk("post_rst_data", hs_data, 13);
    chk("post_rst_lat", hs_lat, 2);

    // Random traffic with input churn after grant.
    for (int i = 0; i < 3000; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? a :
          (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255));
      drive($urandom_range(0, 3), $urandom_range(0, 7), a, b,
            $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
            ($urandom_range(0, 3) != 0));
      step();
    end
    idle(15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
